// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-channel selector with direct select and auto-scan modes
module chan_scan_mux #(
  parameter int W     = 4,
  parameter int N     = 6,
  parameter int SELW  = 3,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic              hold,
  input  logic [N*W-1:0]    data,
  output logic [W-1:0]      out,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  output logic              wrap
);
  localparam int DW = $clog2(DWELL + 1);
  localparam logic [SELW:0]   NUM   = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST  = SELW'(N - 1);
  localparam logic [SELW-1:0] CH1   = SELW'(1);
  localparam logic [DW-1:0]   DMAX  = DW'(DWELL);
  localparam logic [DW-1:0]   D1    = DW'(1);
  typedef enum logic {DIRECT, SCAN} state_t;
  state_t state, state_n;
  logic [SELW-1:0] ch, ch_n, ch_adv, out_ch_n;
  logic [DW-1:0]   dwell, dwell_n;
  logic [W-1:0]    out_n;
  logic            out_valid_n, wrap_n, sel_ok;
  assign sel_ok = {1'b0, sel} < NUM;
  assign ch_adv = (ch == LAST) ? '0 : ch + CH1;
  // state, scan position and every output are registered together
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= DIRECT;
      ch        <= '0;
      dwell     <= '0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_n;
      ch        <= ch_n;
      dwell     <= dwell_n;
      out       <= out_n;
      out_ch    <= out_ch_n;
      out_valid <= out_valid_n;
      wrap      <= wrap_n;
    end
  // mode alone decides the next state; switching costs no dead cycle
  always_comb state_n = mode ? SCAN : DIRECT;
  // scan stepping and next output values; leaving scan clears the position
  always_comb begin
    ch_n    = '0;
    dwell_n = '0;
    wrap_n  = 1'b0;
    if (mode) begin
      if (state == DIRECT) begin
        dwell_n = D1;
      end else if (hold) begin
        ch_n    = ch;
        dwell_n = dwell;
      end else if (dwell < DMAX) begin
        ch_n    = ch;
        dwell_n = dwell + D1;
      end else begin
        ch_n    = ch_adv;
        dwell_n = D1;
        wrap_n  = ch == LAST;
      end
    end
    out_ch_n    = mode ? ch_n : sel;
    out_valid_n = mode | sel_ok;
    out_n       = mode ? data[int'(ch_n)*W +: W] : sel_ok ? data[int'(sel)*W +: W] : '0;
  end
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: scoreboard bench with a time-position reference model of the scanner
module tb_chan_scan_mux;
  localparam int W = 4, N = 6, SELW = 3, DWELL = 4, P = N * DWELL;
  logic clk = 1'b0, reset = 1'b1, mode = 1'b0, hold = 1'b0;
  logic [SELW-1:0] sel = '0;
  logic [N*W-1:0]  data = '0;
  logic [W-1:0]    out;
  logic [SELW-1:0] out_ch;
  logic            out_valid, wrap;
  typedef struct packed {
    logic [W-1:0]    o;
    logic [SELW-1:0] c;
    logic            v;
    logic            w;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit m_scan = 0;
  int t = 0;
  chan_scan_mux #(.W(W), .N(N), .SELW(SELW), .DWELL(DWELL)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .hold(hold), .data(data),
    .out(out), .out_ch(out_ch), .out_valid(out_valid), .wrap(wrap)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] chan(input logic [N*W-1:0] d, input int k);
    return d[k*W +: W];
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  // Model: scan position is the count of unheld cycles since entry, modulo one full period
  task automatic drive(input logic m, input logic [SELW-1:0] s, input logic h, input logic [N*W-1:0] d);
    exp_t e;
    int c;
    mode = m;
    sel  = s;
    hold = h;
    data = d;
    e.w = 1'b0;
    if (!m) begin
      m_scan = 0;
      e.v = int'(s) < N;
      e.o = e.v ? chan(d, int'(s)) : '0;
      e.c = s;
    end else begin
      if (!m_scan) begin
        m_scan = 1;
        t = 0;
      end else if (!h) begin
        t = (t + 1) % P;
        e.w = (t == 0);
      end
      c = t / DWELL;
      e.o = chan(d, c);
      e.c = SELW'(c);
      e.v = 1'b1;
    end
    q.push_back(e);
  endtask
  // Monitor: outputs are presented every cycle; compare just after each edge
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("out", 32'(out), 32'(e.o));
      check("out_ch", 32'(out_ch), 32'(e.c));
      check("out_valid", 32'(out_valid), 32'(e.v));
      check("wrap", 32'(wrap), 32'(e.w));
    end
  end
  initial begin
    logic [N*W-1:0] d;
    logic m;
    int sels[5] = '{3, 6, 7, 0, 5};
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_wrap", 32'(wrap), 0);
    for (int k = 0; k < N; k++) d[k*W +: W] = W'(k + 1);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, d);
    foreach (sels[i]) begin
      @(negedge clk);
      drive(0, SELW'(sels[i]), 0, d);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(1, 0, 0, d);
    end
    @(negedge clk);
    drive(0, 2, 0, d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1, 0, 0, d);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) d[2*W +: W] = W'(4'hA);
      @(negedge clk);
      drive(1, 0, 1, d);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, 0, d);
    end
    @(negedge clk);
    drive(0, 1, 0, d);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1, 0, 0, d);
    end
    m = 1'b1;
    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(15) == 0) ? ~m : m;
      @(negedge clk);
      drive(m, SELW'($urandom), $urandom_range(3) == 0, (N*W)'($urandom));
    end
    @(negedge clk);
    drive(0, 0, 0, d);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(1, 0, 0, d);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 0);
    check("async_rst_out_ch", 32'(out_ch), 0);
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_wrap", 32'(wrap), 0);
    m_scan = 0;
    t = 0;
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, d);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1, 0, 0, d);
    end
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
